// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, constants and helpers for the DMA priority resolver
// Purpose: FSM state type, channel count, command-bit indices and the one-hot to index helper.
// Ports: none (package).
package dma_pkg;

  localparam int NCH = 4;

  // Command register bit positions driving ctrlDisable/rotPri/dreqSenseLow/dackSenseHi.
  localparam int CMD_DISABLE = 2;
  localparam int CMD_ROT     = 4;
  localparam int CMD_DREQLOW = 6;
  localparam int CMD_DACKHI  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } pr_state_t;

  function automatic logic [1:0] onehot2idx(input logic [NCH-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_rot_prio_enc.sv
// rtl/dma_rot_prio_enc.sv - fixed/rotating priority encoder returning a one-hot winner
// Purpose: picks one requesting channel; fixed mode favours ch0, rotating mode starts after low_pri_i.
// Ports:
//   req_i     in  4  qualified requests
//   low_pri_i in  2  channel that currently holds lowest priority
//   rot_i     in  1  1 = rotating priority, 0 = fixed
//   win_o     out 4  one-hot winner, 0 when no request
module dma_rot_prio_enc
  import dma_pkg::*;
(
  input  logic [NCH-1:0] req_i,
  input  logic [1:0]     low_pri_i,
  input  logic           rot_i,
  output logic [NCH-1:0] win_o
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      // 2-bit sum wraps naturally, so lowPri=3 starts the search at ch0.
      idx = rot_i ? (low_pri_i + 2'(i + 1)) : 2'(i);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// rtl/dma_priority_resolver.sv - 8237A-style DMA priority resolver and DACK driver
// Purpose: synchronise and qualify DREQ, hold software requests, arbitrate in IDLE,
//          present a one-hot grant to timing control and drive DACK during service.
// Ports:
//   CLK, RESET (async active-low)
//   DREQ[3:0], mask[3:0], wrReq, reqData[2:0]      request inputs
//   ctrlDisable, rotPri, dreqSenseLow, dackSenseHi  command bits
//   hrq, validDACK, tcEop                           timing-control handshake
//   VALID_DREQ0..3                                  one-hot grant
//   DACK[3:0]                                       acknowledge pins
//   statusReq[3:0]                                  registered effective requests
module dma_priority_resolver
  import dma_pkg::pr_state_t, dma_pkg::IDLE, dma_pkg::REQ, dma_pkg::SVC, dma_pkg::onehot2idx;
#(
  parameter int NCH     = 4,
  parameter int SYNC_FF = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic [NCH-1:0] mask,
  input  logic           wrReq,
  input  logic [2:0]     reqData,
  input  logic           ctrlDisable,
  input  logic           rotPri,
  input  logic           dreqSenseLow,
  input  logic           dackSenseHi,
  input  logic           hrq,
  input  logic           validDACK,
  input  logic           tcEop,
  output logic           VALID_DREQ0,
  output logic           VALID_DREQ1,
  output logic           VALID_DREQ2,
  output logic           VALID_DREQ3,
  output logic [NCH-1:0] DACK,
  output logic [NCH-1:0] statusReq
);

  logic [SYNC_FF-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0] dreq_sync, eff_req, win, dack_act;
  logic [NCH-1:0] grant_q, grant_d, sw_req_q, sw_req_d, status_q;
  logic [1:0]     low_pri_q, low_pri_d, grant_ch;
  pr_state_t      state_q, state_d;

  assign dreq_sync = sync_q[SYNC_FF-1] ^ {NCH{dreqSenseLow}};
  assign eff_req   = (dreq_sync & ~mask) | sw_req_q;
  assign grant_ch  = onehot2idx(grant_q);

  dma_rot_prio_enc u_enc (
    .req_i     (eff_req),
    .low_pri_i (low_pri_q),
    .rot_i     (rotPri),
    .win_o     (win)
  );

  // Terminal count is applied after the register write so it wins on a shared bit.
  always_comb begin
    sw_req_d = sw_req_q;
    if (wrReq) sw_req_d[reqData[1:0]] = reqData[2];
    if (tcEop && state_q == SVC) sw_req_d[grant_ch] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    low_pri_d = low_pri_q;
    unique case (state_q)
      IDLE: begin
        if (eff_req != '0 && !ctrlDisable) begin
          grant_d = win;
          state_d = REQ;
        end
      end
      REQ: begin
        if (hrq && validDACK) begin
          state_d = SVC;
        end else if (!eff_req[grant_ch] && !hrq) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      SVC: begin
        // TC/EOP and a demand/single-mode drop of validDACK end service identically.
        if (tcEop || !validDACK) begin
          state_d = IDLE;
          grant_d = '0;
          if (rotPri) low_pri_d = grant_ch;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q    <= '0;
      sw_req_q  <= '0;
      status_q  <= '0;
      grant_q   <= '0;
      low_pri_q <= 2'd3;
      state_q   <= IDLE;
    end else begin
      sync_q[0] <= DREQ;
      for (int i = 1; i < SYNC_FF; i++) sync_q[i] <= sync_q[i-1];
      sw_req_q  <= sw_req_d;
      status_q  <= eff_req;
      grant_q   <= grant_d;
      low_pri_q <= low_pri_d;
      state_q   <= state_d;
    end
  end

  // hrq dropping alone keeps SVC but releases the pin.
  assign dack_act = (state_q == SVC && validDACK && hrq) ? grant_q : '0;
  assign DACK     = dack_act ^ {NCH{~dackSenseHi}};

  assign VALID_DREQ0 = grant_q[0];
  assign VALID_DREQ1 = grant_q[1];
  assign VALID_DREQ2 = grant_q[2];
  assign VALID_DREQ3 = grant_q[3];
  assign statusReq   = status_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb/tb_dma_priority_resolver.sv - scoreboard bench for dma_priority_resolver
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, mask, DACK, statusReq;
  logic       wrReq, ctrlDisable, rotPri, dreqSenseLow, dackSenseHi;
  logic [2:0] reqData;
  logic       hrq, validDACK, tcEop;
  logic       VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_v = 4'b0;
  logic [3:0] valid_v;

  assign valid_v = {VALID_DREQ3, VALID_DREQ2, VALID_DREQ1, VALID_DREQ0};

  dma_priority_resolver #(.NCH(4), .SYNC_FF(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .mask(mask), .wrReq(wrReq), .reqData(reqData),
    .ctrlDisable(ctrlDisable), .rotPri(rotPri), .dreqSenseLow(dreqSenseLow),
    .dackSenseHi(dackSenseHi), .hrq(hrq), .validDACK(validDACK), .tcEop(tcEop),
    .VALID_DREQ0(VALID_DREQ0), .VALID_DREQ1(VALID_DREQ1), .VALID_DREQ2(VALID_DREQ2),
    .VALID_DREQ3(VALID_DREQ3), .DACK(DACK), .statusReq(statusReq)
  );

  always #5 CLK = ~CLK;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every new grant is compared against the next expected grant.
  always @(negedge CLK) begin
    if (valid_v != 4'b0 && prev_v == 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got %b expected none", valid_v);
      end else begin
        check4("grant", valid_v, exp_q.pop_front());
      end
    end
    if ($countones(valid_v) > 1) begin
      checks++; errors++;
      $display("FAIL grant_onehot: got %b expected at most one bit", valid_v);
    end
    prev_v = valid_v;
  end

  task automatic wait_grant(input int budget);
    int n = 0;
    do begin @(negedge CLK); n++; end while (valid_v == 4'b0 && n < budget);
    if (valid_v == 4'b0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got none expected grant within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin @(negedge CLK); n++; end while (valid_v != 4'b0 && n < budget);
    check4(name, valid_v, 4'b0);
  endtask

  // Drive one service: raise hrq/validDACK (changing DREQ), check DACK, then end by tcEop or validDACK drop.
  task automatic serve(input logic [3:0] ch, input logic [3:0] new_dreq, input bit use_tc);
    @(negedge CLK);
    hrq = 1'b1; validDACK = 1'b1; DREQ = new_dreq;
    @(negedge CLK);
    check4("svc_dack", DACK, dackSenseHi ? ch : ~ch);
    check4("svc_valid", valid_v, ch);
    if (use_tc) tcEop = 1'b1;
    else validDACK = 1'b0;
    @(negedge CLK);
    tcEop = 1'b0; hrq = 1'b0; validDACK = 1'b0;
    check4("svc_exit", valid_v, 4'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; DREQ = 4'b0; mask = 4'b0; wrReq = 1'b0; reqData = 3'b0;
    ctrlDisable = 1'b0; rotPri = 1'b0; dreqSenseLow = 1'b0; dackSenseHi = 1'b0;
    hrq = 1'b0; validDACK = 1'b0; tcEop = 1'b0;
    repeat (3) @(negedge CLK);
    check4("rst_valid", valid_v, 4'b0);
    check4("rst_dack_lo", DACK, 4'b1111);
    check4("rst_status", statusReq, 4'b0);
    dackSenseHi = 1'b1;
    #1 check4("rst_dack_hi", DACK, 4'b0000);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Fixed priority: ch1 beats ch3, ch3 follows once ch1 is released.
    exp_q.push_back(4'b0010);
    DREQ = 4'b1010;
    wait_grant(8);
    check4("fixed_status", statusReq, 4'b1010);
    exp_q.push_back(4'b1000);
    serve(4'b0010, 4'b1000, 1);
    wait_grant(8);
    serve(4'b1000, 4'b0000, 1);
    repeat (3) @(negedge CLK);

    // Rotating priority: ch1 -> ch3 -> ch0 (wrap), last one ends by validDACK drop.
    rotPri = 1'b1;
    exp_q.push_back(4'b0010);
    DREQ = 4'b0010;
    wait_grant(8);
    exp_q.push_back(4'b1000);
    serve(4'b0010, 4'b1011, 1);
    wait_grant(8);
    exp_q.push_back(4'b0001);
    serve(4'b1000, 4'b0011, 1);
    wait_grant(8);
    serve(4'b0001, 4'b0000, 0);
    repeat (3) @(negedge CLK);

    // Mask blocks ch0; software request grants ch2 and tcEop clears it.
    mask = 4'b0001; DREQ = 4'b0001;
    repeat (6) @(negedge CLK);
    check4("masked_no_grant", valid_v, 4'b0);
    check4("masked_status", statusReq, 4'b0);
    exp_q.push_back(4'b0100);
    wrReq = 1'b1; reqData = 3'b110;
    @(negedge CLK);
    wrReq = 1'b0;
    wait_grant(8);
    check4("swreq_status", statusReq, 4'b0100);
    serve(4'b0100, 4'b0001, 1);
    repeat (4) @(negedge CLK);
    check4("swreq_cleared_valid", valid_v, 4'b0);
    check4("swreq_cleared_status", statusReq, 4'b0);
    DREQ = 4'b0;
    repeat (3) @(negedge CLK);
    mask = 4'b0;

    // Withdrawal in REQ: lowPri stays 2, so next search from ch3 picks ch0 over ch1/ch2.
    exp_q.push_back(4'b0010);
    DREQ = 4'b0010;
    wait_grant(8);
    DREQ = 4'b0000;
    wait_idle("withdraw_valid", 8);
    repeat (2) @(negedge CLK);
    exp_q.push_back(4'b0001);
    DREQ = 4'b0111;
    wait_grant(8);
    serve(4'b0001, 4'b0000, 1);
    repeat (3) @(negedge CLK);

    // Polarity: active-low DREQ and active-low DACK, fixed priority.
    rotPri = 1'b0; dackSenseHi = 1'b0; dreqSenseLow = 1'b1; DREQ = 4'b1110;
    exp_q.push_back(4'b0001);
    wait_grant(8);
    serve(4'b0001, 4'b1111, 1);
    repeat (4) @(negedge CLK);
    check4("polarity_idle", valid_v, 4'b0);

    // Restore polarity under ctrlDisable so the sense flip cannot grant.
    ctrlDisable = 1'b1; dreqSenseLow = 1'b0; dackSenseHi = 1'b1; DREQ = 4'b0000;
    repeat (5) @(negedge CLK);
    check4("disable_no_grant", valid_v, 4'b0);
    ctrlDisable = 1'b0;
    rotPri = 1'b1;

    // Reset mid-service: lowPri=0 so ch2 wins; after reset lowPri=3 makes ch0 win.
    exp_q.push_back(4'b0100);
    DREQ = 4'b0100;
    wait_grant(8);
    hrq = 1'b1; validDACK = 1'b1;
    @(negedge CLK);
    check4("pre_reset_dack", DACK, 4'b0100);
    #2 RESET = 1'b0;
    #1;
    check4("reset_valid", valid_v, 4'b0);
    check4("reset_dack", DACK, 4'b0000);
    hrq = 1'b0; validDACK = 1'b0; DREQ = 4'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    exp_q.push_back(4'b0001);
    DREQ = 4'b1111;
    wait_grant(8);
    serve(4'b0001, 4'b0000, 1);
    repeat (4) @(negedge CLK);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
